// File: rtl/cc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cc_pkg
// Purpose  : Shared types and constants for the cache-controller miss path:
//            AXI burst encodings, fixed AR burst shape (8 x 64-bit beats per
//            64 B line) and the miss-request FSM state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cc_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP = 2'b10;

   localparam int         CC_LINE_BEATS  = 8;
   localparam logic [3:0] CC_ARLEN       = 4'd7;   // CC_LINE_BEATS - 1
   localparam logic [2:0] CC_ARSIZE      = 3'd3;   // 8 bytes per beat

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } miss_req_state_t;

endpackage : cc_pkg
`default_nettype wire

// File: rtl/cc_outstanding_cnt.sv
`default_nettype none
// ============================================================================
// Module   : cc_outstanding_cnt
// Purpose  : 4-bit up/down saturating counter of AR bursts issued but not yet
//            retired by their R last beat.
// Ports    : clk, rst_n (sync, active-low)
//            inc_i       - AR handshake this cycle
//            dec_i       - R last-beat handshake this cycle
//            count_o     - current outstanding count
//            below_max_o - count < MAX_OUTSTANDING (room for another burst)
// Revision : 1.0 - initial release
// ============================================================================
module cc_outstanding_cnt #(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc_i,
   input  logic       dec_i,
   output logic [3:0] count_o,
   output logic       below_max_o
);

   localparam logic [3:0] c_MAX_CNT = 4'(MAX_OUTSTANDING);

   logic [3:0] r_count;
   logic       w_inc_ok;
   logic       w_dec_ok;

   // Saturate at both ends; a stray last beat at zero is dropped.
   assign w_inc_ok = inc_i & (r_count != 4'hF);
   assign w_dec_ok = dec_i & (r_count != 4'h0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= 4'd0;
      end else begin
         case ({w_inc_ok, w_dec_ok})
            2'b10:   r_count <= r_count + 4'd1;
            2'b01:   r_count <= r_count - 4'd1;
            default: r_count <= r_count;   // none, or both cancel out
         endcase
      end
   end

`ifndef SYNTHESIS
   // An R last beat with nothing outstanding means the memory side is
   // returning data nobody asked for.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(dec_i && (r_count == 4'd0)));
      end
   end
`endif

   assign count_o     = r_count;
   assign below_max_o = (r_count < c_MAX_CNT);

endmodule : cc_outstanding_cnt
`default_nettype wire

// File: rtl/cc_miss_req_unit.sv
`default_nettype none
// ============================================================================
// Module   : cc_miss_req_unit
// Purpose  : Accepts line-miss requests from the tag-compare stage, pushes the
//            full miss address into the miss-address FIFO and issues one
//            8-beat 64-bit AXI AR burst per miss. Outstanding bursts are
//            counted and retired on the R last beat.
// Config   : CC_AR_LINE_ALIGN_EN - when defined, AR is line aligned with INCR
//            bursts; otherwise beat aligned with WRAP (critical word first).
// Ports    : clk, rst_n (sync, active-low)
//            miss_req_*      - miss request handshake (valid/ready/addr)
//            mem_ar*         - AXI AR channel master
//            mem_r{valid,ready,last}_i - snooped R channel
//            miss_addr_fifo_* - miss-address FIFO push side
//            outstanding_o   - outstanding burst count
// Revision : 1.0 - initial release
// ============================================================================
module cc_miss_req_unit
   import cc_pkg::*;
#(
   parameter int         MAX_OUTSTANDING = 2,
   parameter logic [3:0] ARID            = 4'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        miss_req_valid_i,
   input  logic [31:0] miss_req_addr_i,
   output logic        miss_req_ready_o,
   output logic [3:0]  mem_arid_o,
   output logic [31:0] mem_araddr_o,
   output logic [3:0]  mem_arlen_o,
   output logic [2:0]  mem_arsize_o,
   output logic [1:0]  mem_arburst_o,
   output logic        mem_arvalid_o,
   input  logic        mem_arready_i,
   input  logic        mem_rvalid_i,
   input  logic        mem_rready_i,
   input  logic        mem_rlast_i,
   input  logic        miss_addr_fifo_full_i,
   output logic        miss_addr_fifo_wren_o,
   output logic [31:0] miss_addr_fifo_wdata_o,
   output logic [3:0]  outstanding_o
);

   miss_req_state_t r_state;
   miss_req_state_t w_state_nxt;
   logic [31:0]     r_araddr;
   logic [31:0]     w_ar_addr;
   logic [1:0]      w_arburst;
   logic            w_below_max;
   logic            w_ready;
   logic            w_accept;
   logic            w_arvalid;
   logic            w_ar_hs;
   logic            w_rlast_hs;

`ifdef CC_AR_LINE_ALIGN_EN
   assign w_ar_addr = {miss_req_addr_i[31:6], 6'b0};
   assign w_arburst = AXI_BURST_INCR;
`else
   assign w_ar_addr = {miss_req_addr_i[31:3], 3'b0};
   assign w_arburst = AXI_BURST_WRAP;
`endif

   // Ready is qualified by rst_n so nothing is accepted or pushed while the
   // block is held in reset.
   assign w_ready  = rst_n & (r_state == ST_IDLE) & ~miss_addr_fifo_full_i & w_below_max;
   assign w_accept = miss_req_valid_i & w_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_arvalid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            w_arvalid = 1'b1;
            if (mem_arready_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_araddr <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_araddr <= w_ar_addr;
         end
      end
   end

   // A pending AR is abandoned immediately when reset asserts.
   assign w_ar_hs    = mem_arvalid_o & mem_arready_i;
   assign w_rlast_hs = mem_rvalid_i & mem_rready_i & mem_rlast_i;

   cc_outstanding_cnt #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_outstanding_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .inc_i       (w_ar_hs),
      .dec_i       (w_rlast_hs),
      .count_o     (outstanding_o),
      .below_max_o (w_below_max)
   );

   assign miss_req_ready_o       = w_ready;
   assign miss_addr_fifo_wren_o  = w_accept;
   assign miss_addr_fifo_wdata_o = miss_req_addr_i;

   assign mem_arvalid_o = w_arvalid & rst_n;
   assign mem_araddr_o  = r_araddr;
   assign mem_arid_o    = ARID;
   assign mem_arlen_o   = CC_ARLEN;
   assign mem_arsize_o  = CC_ARSIZE;
   assign mem_arburst_o = w_arburst;

endmodule : cc_miss_req_unit
`default_nettype wire
